// File: rtl/calculator_pkg.sv
// Shared types and opcode constants for the calculator core and its ALU.
package calculator_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ALU_ADD = OP_ADD,
    ALU_SUB = OP_SUB,
    ALU_MUL = OP_MUL,
    ALU_DIV = OP_DIV
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } alu_state_t;

  function automatic logic is_single_cycle(alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/calculator_alu_full_adder.sv
// Ripple-carry adder shared by the ALU for add/sub, trial subtraction and negation.
module full_adder #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic c;

  always_comb begin
    sum = '0;
    c   = carry_in;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carry_out = c;
  end

endmodule

// File: rtl/calculator_alu.sv
// Multi-cycle ALU: 1-cycle ADD/SUB, shift-add MUL and restoring DIV over magnitudes.
// Optional macro ALU_OVERFLOW_ERR_EN turns arithmetic overflow into o_error.
module calculator_alu
  import calculator_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [1:0]            i_op,
  input  logic                  i_signed,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_error,
  output logic                  o_result_valid,
  input  logic                  i_result_ready
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  alu_state_t      state;
  alu_op_t         op;
  alu_op_t         req_op;
  logic            sgn;
  logic            neg;
  logic [CW-1:0]   count;
  logic [W-1:0]    b_mag;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    rem;
  logic [W-1:0]    result;
  logic            error;
  logic            valid;

  logic [W:0]      arith_a;
  logic [W:0]      arith_b;
  logic [W:0]      arith_sum;
  logic            arith_cin;
  logic            arith_co;
  logic [W:0]      nega_in;
  logic [W:0]      nega_sum;
  logic [W:0]      negb_sum;
  logic            nega_co;
  logic            negb_co;
  logic [W-1:0]    a_mag_in;
  logic [W-1:0]    b_mag_in;
  logic [W-1:0]    fixed;
  logic [W:0]      shifted;
  logic            as_err;
  logic            fix_err;
  logic            unused_bits;

  assign req_op = alu_op_t'(i_op);

  // One negator serves |A| at accept and the final sign fix in FIX.
  assign nega_in = (state == S_FIX) ? ~{1'b0, prod[W-1:0]} : ~{1'b0, i_a};

  full_adder #(.WIDTH(W + 1)) u_neg_a (
    .a         (nega_in),
    .b         ('0),
    .carry_in  (1'b1),
    .sum       (nega_sum),
    .carry_out (nega_co)
  );

  full_adder #(.WIDTH(W + 1)) u_neg_b (
    .a         (~{1'b0, i_b}),
    .b         ('0),
    .carry_in  (1'b1),
    .sum       (negb_sum),
    .carry_out (negb_co)
  );

  full_adder #(.WIDTH(W + 1)) u_arith (
    .a         (arith_a),
    .b         (arith_b),
    .carry_in  (arith_cin),
    .sum       (arith_sum),
    .carry_out (arith_co)
  );

  assign a_mag_in    = (i_signed && i_a[W-1]) ? nega_sum[W-1:0] : i_a;
  assign b_mag_in    = (i_signed && i_b[W-1]) ? negb_sum[W-1:0] : i_b;
  assign fixed       = neg ? nega_sum[W-1:0] : prod[W-1:0];
  assign shifted     = {rem, prod[W-1]};
  assign unused_bits = ^{nega_co, negb_co, nega_sum[W], negb_sum[W]};

  always_comb begin
    arith_a   = {1'b0, i_a};
    arith_b   = {1'b0, i_b};
    arith_cin = 1'b0;
    if (state == S_IDLE) begin
      if (req_op == ALU_SUB) begin
        arith_b   = ~{1'b0, i_b};
        arith_cin = 1'b1;
      end
    end else if (op == ALU_MUL) begin
      arith_a = {1'b0, prod[2*W-1:W]};
      arith_b = {1'b0, b_mag};
    end else begin
      // Carry out of the trial subtraction means no borrow: quotient bit is 1.
      arith_a   = shifted;
      arith_b   = ~{1'b0, b_mag};
      arith_cin = 1'b1;
    end
  end

  always_comb begin
    as_err  = 1'b0;
    fix_err = 1'b0;
`ifdef ALU_OVERFLOW_ERR_EN
    if (i_signed) begin
      as_err = (i_a[W-1] == (i_b[W-1] ^ (req_op == ALU_SUB))) &&
               (arith_sum[W-1] != i_a[W-1]);
    end else begin
      as_err = arith_sum[W];
    end
    // Magnitude test: a negative result may reach exactly 2^(W-1), a positive one may not.
    if (op == ALU_MUL) begin
      if (!sgn) fix_err = |prod[2*W-1:W];
      else      fix_err = (|prod[2*W-1:W]) || (prod[W-1] && (!neg || (|prod[W-2:0])));
    end else begin
      fix_err = sgn && !neg && prod[W-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op     <= ALU_ADD;
      sgn    <= 1'b0;
      neg    <= 1'b0;
      count  <= '0;
      b_mag  <= '0;
      prod   <= '0;
      rem    <= '0;
      result <= '0;
      error  <= 1'b0;
      valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            op  <= req_op;
            sgn <= i_signed;
            neg <= i_signed & (i_a[W-1] ^ i_b[W-1]);
            if (is_single_cycle(req_op)) begin
              result <= as_err ? '0 : arith_sum[W-1:0];
              error  <= as_err;
              valid  <= 1'b1;
              state  <= S_DONE;
            end else if (req_op == ALU_DIV && i_b == '0) begin
              result <= '0;
              error  <= 1'b1;
              valid  <= 1'b1;
              state  <= S_DONE;
            end else begin
              prod  <= {{W{1'b0}}, a_mag_in};
              rem   <= '0;
              b_mag <= b_mag_in;
              count <= CW'(W);
              state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          if (op == ALU_MUL) begin
            prod <= prod[0] ? {arith_sum, prod[W-1:1]} : {1'b0, prod[2*W-1:1]};
          end else begin
            rem          <= arith_co ? arith_sum[W-1:0] : shifted[W-1:0];
            prod[W-1:0] <= {prod[W-2:0], arith_co};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_err ? '0 : fixed;
          error  <= fix_err;
          valid  <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (i_result_ready) begin
            valid <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ready        = (state == S_IDLE);
  assign o_result       = result;
  assign o_error        = error;
  assign o_result_valid = valid;

endmodule

// File: tb/tb_calculator_alu.sv
// Scoreboard bench for calculator_alu: integer reference model, queued expectations, decoupled monitor.
module tb_calculator_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic [1:0]   i_op = 2'b00;
  logic         i_signed = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] o_result;
  logic         o_error;
  logic         o_result_valid;
  logic         i_result_ready = 1'b0;

  calculator_alu #(.DATA_WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_a            (i_a),
    .i_b            (i_b),
    .i_op           (i_op),
    .i_signed       (i_signed),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .o_result       (o_result),
    .o_error        (o_error),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hs_cycle = -100;
  int   stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer arithmetic, then range check against the W-bit result type.
  function automatic exp_t model(input logic [1:0] op, input logic s,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint av, bv, r, lo, hi;
    bit     div0;
    av   = s ? longint'($signed(a)) : longint'(a);
    bv   = s ? longint'($signed(b)) : longint'(b);
    lo   = s ? -(longint'(1) << (W - 1)) : 0;
    hi   = s ? (longint'(1) << (W - 1)) - 1 : (longint'(1) << W) - 1;
    div0 = 1'b0;
    r    = 0;
    case (op)
      2'b00: r = av + bv;
      2'b01: r = av - bv;
      2'b10: r = av * bv;
      default: if (bv == 0) div0 = 1'b1; else r = av / bv;
    endcase
    e.res = r[W-1:0];
    e.err = 1'b0;
    e.lat = (op[1] && !div0) ? W + 2 : 1;
    e.acc = 0;
`ifdef ALU_OVERFLOW_ERR_EN
    if (!div0 && (r < lo || r > hi)) begin
      e.res = '0;
      e.err = 1'b1;
    end
`else
    if (lo > hi) e.err = 1'b1;
`endif
    if (div0) begin
      e.res = '0;
      e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = W'(1);
      2: v = '1;
      3: v = {1'b1, {(W-1){1'b0}}};
      4: v = {1'b0, {(W-1){1'b1}}};
      5: v = W'($urandom_range(0, 15));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Waits for o_ready, issues one request and queues its expected response.
  task automatic issue(input logic [1:0] op, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit noise, input bit keep, output int acc);
    exp_t e;
    int   n;
    n   = 0;
    acc = -1;
    forever begin
      @(negedge clk);
      if (o_ready) begin
        i_op = op; i_signed = s; i_a = a; i_b = b; i_valid = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        e     = model(op, s, a, b);
        e.acc = acc;
        sb.push_back(e);
        if (!keep) i_valid = 1'b0;
        return;
      end
      if (noise) begin
        i_valid = 1'($urandom_range(0, 1));
        i_a = W'($urandom); i_b = W'($urandom); i_op = 2'($urandom_range(0, 3));
      end
      n++;
      if (n > 300) begin
        tests++; fails++;
        $display("FAIL issue_timeout: o_ready stayed %0b for %0d cycles", o_ready, n);
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || o_result_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
    end
  endtask

  // Monitor: pops on the first cycle of each result, checks stability while held.
  initial begin
    exp_t         e;
    logic         prev;
    logic [W-1:0] held_r;
    logic         held_e;
    prev = 1'b0; held_r = '0; held_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
        i_result_ready = 1'b0;
        continue;
      end
      if (o_result_valid) begin
        check("ready_low_in_done", 32'(o_ready), 32'd0);
        if (!prev) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_result: result %0h error %0b with nothing queued", o_result, o_error);
          end else begin
            e = sb.pop_front();
            check("result", 32'(o_result), 32'(e.res));
            check("error", 32'(o_error), 32'(e.err));
            check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          end
          held_r = o_result;
          held_e = o_error;
        end else begin
          check("stable_result", 32'(o_result), 32'(held_r));
          check("stable_error", 32'(o_error), 32'(held_e));
        end
        prev = 1'b1;
        if (stall > 0) begin
          stall--;
          i_result_ready = 1'b0;
        end else begin
          i_result_ready = ($urandom_range(0, 3) != 0);
        end
        if (i_result_ready) hs_cycle = cyc + 1;
      end else begin
        prev = 1'b0;
        i_result_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(o_ready), 32'd1);
    check("reset_valid", 32'(o_result_valid), 32'd0);
    check("reset_result", 32'(o_result), 32'd0);
    check("reset_error", 32'(o_error), 32'd0);
    rst_n = 1'b1;

    issue(2'b00, 1'b0, 16'h0003, 16'h0004, 0, 0, acc);
    issue(2'b01, 1'b0, 16'h0000, 16'h0001, 0, 0, acc);
    issue(2'b10, 1'b1, 16'hFFFD, 16'h0007, 0, 0, acc);
    issue(2'b10, 1'b0, 16'h00FF, 16'h0101, 0, 0, acc);
    issue(2'b11, 1'b0, 16'h0064, 16'h0007, 0, 0, acc);
    issue(2'b11, 1'b1, 16'hFF9C, 16'h0007, 0, 0, acc);
    issue(2'b11, 1'b1, 16'h0064, 16'hFFF9, 0, 0, acc);
    issue(2'b11, 1'b0, 16'h1234, 16'h0000, 0, 0, acc);
    issue(2'b00, 1'b1, 16'h7FFF, 16'h0001, 0, 0, acc);
    issue(2'b01, 1'b1, 16'h8000, 16'h0001, 0, 0, acc);
    issue(2'b11, 1'b1, 16'h8000, 16'hFFFF, 0, 0, acc);
    issue(2'b10, 1'b1, 16'h8000, 16'h0001, 0, 0, acc);
    issue(2'b10, 1'b1, 16'h8000, 16'hFFFF, 0, 0, acc);
    issue(2'b00, 1'b0, 16'hFFFF, 16'h0001, 0, 0, acc);

    for (int i = 0; i < 160; i++) begin
      issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(),
            1'($urandom_range(0, 1)), 0, acc);
    end
    drain();

    // Result held for 5 cycles while a request waits; accept follows the bubble.
    stall = 5;
    issue(2'b00, 1'b0, 16'h0011, 16'h0022, 0, 1, acc);
    issue(2'b01, 1'b0, 16'h0100, 16'h0001, 0, 0, acc2);
    check("accept_after_bubble", 32'(acc2), 32'(hs_cycle + 1));
    drain();

    // Abort a multiply with reset: its result must never appear.
    issue(2'b10, 1'b0, 16'h1234, 16'h0056, 0, 0, acc);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clk);
    check("abort_ready", 32'(o_ready), 32'd1);
    check("abort_valid", 32'(o_result_valid), 32'd0);
    check("abort_result", 32'(o_result), 32'd0);
    rst_n = 1'b1;
    repeat (W + 6) @(negedge clk);
    issue(2'b00, 1'b0, 16'h1000, 16'h0234, 0, 0, acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
